// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Request/response bus between a load/store initiator and dmem_responder.
//   req_valid/req_ready : request handshake; the request fields are sampled on acceptance
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I load/store size code
//   req_addr            : byte address
//   req_wdata           : store data, right-aligned
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load result (0 for stores and faults)
//   rsp_err             : access faulted
// Modports: master = initiator side, slave = responder side.
interface dmem_responder_if #(
    parameter int addr_data_width = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [2:0]                 req_funct3;
    logic [addr_data_width-1:0] req_addr;
    logic [addr_data_width-1:0] req_wdata;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [addr_data_width-1:0] rsp_rdata;
    logic                       rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for an RV32I load/store unit. It accepts one request at a time,
// inserts WAIT_CYCLES wait states, performs the access on the edge that enters RESP,
// and holds the response until the initiator takes it.
// Ports:
//   clk1   : clock, all state updates on the rising edge
//   reset1 : asynchronous active-high reset (memory contents are kept)
//   bus    : dmem_responder_if slave modport (request and response handshakes)
//   busy   : high whenever the FSM is not in IDLE
// The byte-lane datapath works on 32-bit memory words (the low 32 bits of the bus).
module dmem_responder #(
    parameter int addr_data_width = 32,
    parameter int DEPTH_WORDS     = 256,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic              clk1,
    input  logic              reset1,
    dmem_responder_if.slave   bus,
    output logic              busy
);
    localparam int W     = addr_data_width;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t       state_reg, state_next;
    logic [3:0]   wait_cnt_reg, wait_cnt_next;

    logic         we_reg;
    logic [2:0]   funct3_reg;
    logic [W-1:0] addr_reg;
    logic [W-1:0] wdata_reg;
    logic [W-1:0] rdata_reg;
    logic         err_reg;

    logic         accept;
    logic         enter_resp;

    // Fields of the access being performed. With zero wait states the access happens on
    // the acceptance edge itself, before the latched copies exist, so take the live inputs.
    logic         acc_we;
    logic [2:0]   acc_funct3;
    logic [W-1:0] acc_addr;
    logic [W-1:0] acc_wdata;
    logic [IDX_W-1:0] acc_idx;

    logic         acc_err;
    logic         mem_we;
    logic [3:0]   byte_en;
    logic [31:0]  wr_word;
    logic [31:0]  rd_word;
    logic [W-1:0] load_val;

    assign accept     = (state_reg == ST_IDLE) && bus.req_valid;
    assign enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);

    assign acc_we     = accept ? bus.req_we     : we_reg;
    assign acc_funct3 = accept ? bus.req_funct3 : funct3_reg;
    assign acc_addr   = accept ? bus.req_addr   : addr_reg;
    assign acc_wdata  = accept ? bus.req_wdata  : wdata_reg;
    assign acc_idx    = acc_addr[IDX_W+1:2];

    // ------------------------------------------------------------------ FSM: state register
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // ------------------------------------------------------------------ FSM: next state
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wait_cnt_next = 4'(WAIT_CYCLES);
                    state_next    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Saturating decrement; RESP is entered on the edge the counter hits 0.
                wait_cnt_next = (wait_cnt_reg == 4'd0) ? 4'd0 : wait_cnt_reg - 4'd1;
                if (wait_cnt_reg <= 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------ FSM: outputs
    always_comb begin
        bus.req_ready = (state_reg == ST_IDLE);
        bus.rsp_valid = (state_reg == ST_RESP);
        bus.rsp_rdata = rdata_reg;
        bus.rsp_err   = err_reg;
        busy          = (state_reg != ST_IDLE);
    end

    // ------------------------------------------------------------------ request capture
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'd0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else if (accept) begin
            we_reg     <= bus.req_we;
            funct3_reg <= bus.req_funct3;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
        end
    end

    // ------------------------------------------------------------------ access decode
    always_comb begin
        acc_err = 1'b0;
        byte_en = 4'b0000;
        wr_word = acc_wdata[31:0];
        if ((acc_addr >> 2) >= W'(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
        if (acc_we) begin
            case (acc_funct3)
                3'b000: begin
                    byte_en = 4'b0001 << acc_addr[1:0];
                    wr_word = {4{acc_wdata[7:0]}};
                end
                3'b001: begin
                    byte_en = acc_addr[1] ? 4'b1100 : 4'b0011;
                    wr_word = {2{acc_wdata[15:0]}};
                    if (acc_addr[0]) acc_err = 1'b1;
                end
                3'b010: begin
                    byte_en = 4'b1111;
                    if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (acc_funct3)
                3'b000, 3'b100: ;
                3'b001, 3'b101: if (acc_addr[0]) acc_err = 1'b1;
                3'b010:         if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
                default:        acc_err = 1'b1;
            endcase
        end
    end

    // Reset gate: a request sitting on the bus while reset is high must not write.
    assign mem_we = enter_resp && acc_we && !acc_err && !reset1;

    // ------------------------------------------------------------------ byte-lane memories
    // One array per lane so each maps onto a plain RAM with a single write enable.
    // Contents are never initialised or reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk1) begin
                if (mem_we && byte_en[gi]) begin
                    lane_mem[acc_idx] <= wr_word[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[acc_idx];
        end
    endgenerate

    // ------------------------------------------------------------------ load formatting
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = rd_word[8*acc_addr[1:0] +: 8];
        sel_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_funct3)
            3'b000:  load_val = {{(W-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{(W-16){sel_half[15]}}, sel_half};
            3'b100:  load_val = {{(W-8){1'b0}}, sel_byte};
            3'b101:  load_val = {{(W-16){1'b0}}, sel_half};
            default: load_val = W'(rd_word);
        endcase
    end

    // ------------------------------------------------------------------ response registers
    // Loaded only on RESP entry, so they stay stable for the whole RESP stall.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (enter_resp) begin
            err_reg   <= acc_err;
            rdata_reg <= (acc_err || acc_we) ? '0 : load_val;
        end
    end
endmodule
